// File: rtl/rf_write_arbiter.sv
// Two-port register-file write arbiter with starvation-bounded priority; one-cycle registered write, ready is combinational.
// Optional read bypass of the in-flight write is compiled when RF_WARB_BYPASS_EN is defined.
module rf_write_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        a_valid,
  input  logic [4:0]  a_addr,
  input  logic [31:0] a_data,
  output logic        a_ready,
  input  logic        b_valid,
  input  logic [4:0]  b_addr,
  input  logic [31:0] b_data,
  output logic        b_ready,
  output logic        rf_we,
  output logic [4:0]  rf_a3,
  output logic [31:0] rf_wd3,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  input  logic [31:0] rd1_in,
  input  logic [31:0] rd2_in,
  output logic [31:0] rd1_out,
  output logic [31:0] rd2_out
);

  typedef enum logic {
    PRIO_A = 1'b0,
    PRIO_B = 1'b1
  } prio_t;

  localparam logic [3:0] LP_LIMIT = 4'(STARVE_LIMIT);

  prio_t       r_state;
  prio_t       w_state_nxt;
  logic [3:0]  r_starve;
  logic [3:0]  w_starve_nxt;
  logic        w_grant_a;
  logic        w_grant_b;
  logic        r_we;
  logic [4:0]  r_a3;
  logic [31:0] r_wd3;

  // Contention is resolved by the priority state; a lone requester always wins.
  always_comb begin
    w_grant_a = 1'b0;
    w_grant_b = 1'b0;
    if (!reset) begin
      if (a_valid && b_valid) begin
        if (r_state == PRIO_B) begin
          w_grant_b = 1'b1;
        end else begin
          w_grant_a = 1'b1;
        end
      end else begin
        w_grant_a = a_valid;
        w_grant_b = b_valid;
      end
    end
  end

  assign a_ready = w_grant_a;
  assign b_ready = w_grant_b;

  always_comb begin
    w_starve_nxt = r_starve;
    if (w_grant_b || !b_valid) begin
      w_starve_nxt = 4'd0;
    end else if (r_starve != 4'hF) begin
      w_starve_nxt = r_starve + 4'd1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      PRIO_A:  if (w_starve_nxt >= LP_LIMIT) w_state_nxt = PRIO_B;
      PRIO_B:  if (w_grant_b) w_state_nxt = PRIO_A;
      default: w_state_nxt = PRIO_A;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= PRIO_A;
      r_starve <= 4'd0;
    end else begin
      r_state  <= w_state_nxt;
      r_starve <= w_starve_nxt;
    end
  end

  // Writes to x0 are consumed but never reach the register file.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_we  <= 1'b0;
      r_a3  <= 5'd0;
      r_wd3 <= 32'd0;
    end else if (w_grant_a) begin
      r_we  <= (a_addr != 5'd0);
      r_a3  <= a_addr;
      r_wd3 <= a_data;
    end else if (w_grant_b) begin
      r_we  <= (b_addr != 5'd0);
      r_a3  <= b_addr;
      r_wd3 <= b_data;
    end else begin
      r_we  <= 1'b0;
    end
  end

  assign rf_we  = r_we;
  assign rf_a3  = r_a3;
  assign rf_wd3 = r_wd3;

`ifdef RF_WARB_BYPASS_EN
  assign rd1_out = (r_we && (ra1 == r_a3) && (ra1 != 5'd0)) ? r_wd3 : rd1_in;
  assign rd2_out = (r_we && (ra2 == r_a3) && (ra2 != 5'd0)) ? r_wd3 : rd2_in;
`else
  logic w_unused_ra;
  assign w_unused_ra = ^{ra1, ra2};
  assign rd1_out = rd1_in;
  assign rd2_out = rd2_in;
`endif

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed-vector bench for rf_write_arbiter (STARVE_LIMIT = 4); expectations are hand-computed constants.
module tb_rf_write_arbiter;

  logic        clk;
  logic        reset;
  logic        a_valid;
  logic [4:0]  a_addr;
  logic [31:0] a_data;
  logic        a_ready;
  logic        b_valid;
  logic [4:0]  b_addr;
  logic [31:0] b_data;
  logic        b_ready;
  logic        rf_we;
  logic [4:0]  rf_a3;
  logic [31:0] rf_wd3;
  logic [4:0]  ra1;
  logic [4:0]  ra2;
  logic [31:0] rd1_in;
  logic [31:0] rd2_in;
  logic [31:0] rd1_out;
  logic [31:0] rd2_out;

  int n_vec;
  int n_err;

  rf_write_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk     (clk),
    .reset   (reset),
    .a_valid (a_valid),
    .a_addr  (a_addr),
    .a_data  (a_data),
    .a_ready (a_ready),
    .b_valid (b_valid),
    .b_addr  (b_addr),
    .b_data  (b_data),
    .b_ready (b_ready),
    .rf_we   (rf_we),
    .rf_a3   (rf_a3),
    .rf_wd3  (rf_wd3),
    .ra1     (ra1),
    .ra2     (ra2),
    .rd1_in  (rd1_in),
    .rd2_in  (rd2_in),
    .rd1_out (rd1_out),
    .rd2_out (rd2_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge; registered outputs are settled afterwards.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_vec   = 0;
    n_err   = 0;
    reset   = 1'b1;
    a_valid = 1'b1;
    a_addr  = 5'd7;
    a_data  = 32'h7777_7777;
    b_valid = 1'b1;
    b_addr  = 5'd8;
    b_data  = 32'h8888_8888;
    ra1     = 5'd0;
    ra2     = 5'd0;
    rd1_in  = 32'd0;
    rd2_in  = 32'd0;

    #1;
    chk("rst_a_ready", {31'd0, a_ready}, 32'd0);
    chk("rst_b_ready", {31'd0, b_ready}, 32'd0);
    tick();
    tick();
    chk("rst_we",  {31'd0, rf_we}, 32'd0);
    chk("rst_a3",  {27'd0, rf_a3}, 32'd0);
    chk("rst_wd3", rf_wd3, 32'd0);

    // A alone
    reset   = 1'b0;
    b_valid = 1'b0;
    a_valid = 1'b1;
    a_addr  = 5'd5;
    a_data  = 32'h0000_1234;
    #1;
    chk("aonly_a_ready", {31'd0, a_ready}, 32'd1);
    chk("aonly_b_ready", {31'd0, b_ready}, 32'd0);
    tick();
    chk("aonly_we",  {31'd0, rf_we}, 32'd1);
    chk("aonly_a3",  {27'd0, rf_a3}, 32'd5);
    chk("aonly_wd3", rf_wd3, 32'h0000_1234);
    a_valid = 1'b0;
    tick();
    chk("idle_we",  {31'd0, rf_we}, 32'd0);
    chk("idle_a3",  {27'd0, rf_a3}, 32'd5);
    chk("idle_wd3", rf_wd3, 32'h0000_1234);

    // Contention: A x4, B on cycle 5, A on cycle 6
    a_valid = 1'b1;
    a_addr  = 5'd10;
    a_data  = 32'h0000_000A;
    b_valid = 1'b1;
    b_addr  = 5'd20;
    b_data  = 32'h0000_000B;
    for (int c = 1; c <= 6; c++) begin
      #1;
      chk($sformatf("cont%0d_a_ready", c), {31'd0, a_ready}, (c == 5) ? 32'd0 : 32'd1);
      chk($sformatf("cont%0d_b_ready", c), {31'd0, b_ready}, (c == 5) ? 32'd1 : 32'd0);
      tick();
      chk($sformatf("cont%0d_a3", c), {27'd0, rf_a3}, (c == 5) ? 32'd20 : 32'd10);
    end
    a_valid = 1'b0;
    b_valid = 1'b0;
    tick();

    // x0 write via B
    b_valid = 1'b1;
    b_addr  = 5'd0;
    b_data  = 32'hFFFF_FFFF;
    #1;
    chk("x0_b_ready", {31'd0, b_ready}, 32'd1);
    tick();
    chk("x0_we", {31'd0, rf_we}, 32'd0);
    b_valid = 1'b0;

    // Back-to-back x1..x4
    for (int i = 1; i <= 4; i++) begin
      a_valid = 1'b1;
      a_addr  = 5'(i);
      a_data  = 32'h100 + 32'(i);
      #1;
      chk($sformatf("b2b%0d_a_ready", i), {31'd0, a_ready}, 32'd1);
      tick();
      chk($sformatf("b2b%0d_we", i), {31'd0, rf_we}, 32'd1);
      chk($sformatf("b2b%0d_a3", i), {27'd0, rf_a3}, 32'(i));
    end
    a_valid = 1'b0;
    tick();
    chk("b2b_end_we", {31'd0, rf_we}, 32'd0);

    // Read bypass of the in-flight write
    a_valid = 1'b1;
    a_addr  = 5'd3;
    a_data  = 32'hAAAA_0001;
    tick();
    a_valid = 1'b0;
    ra1     = 5'd3;
    rd1_in  = 32'hAAAA_AAAA;
    ra2     = 5'd4;
    rd2_in  = 32'h0000_0055;
    #1;
`ifdef RF_WARB_BYPASS_EN
    chk("byp_rd1", rd1_out, 32'hAAAA_0001);
`else
    chk("byp_rd1", rd1_out, 32'hAAAA_AAAA);
`endif
    chk("byp_rd2", rd2_out, 32'h0000_0055);
    tick();
    chk("byp_after_rd1", rd1_out, 32'hAAAA_AAAA);

    // Drive state to PRIO_B, then reset asynchronously mid-cycle
    a_valid = 1'b1;
    a_addr  = 5'd9;
    a_data  = 32'h0000_0099;
    b_valid = 1'b1;
    b_addr  = 5'd11;
    b_data  = 32'h0000_0011;
    for (int c = 1; c <= 4; c++) tick();
    chk("pre_rst_we", {31'd0, rf_we}, 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_we",      {31'd0, rf_we}, 32'd0);
    chk("arst_a3",      {27'd0, rf_a3}, 32'd0);
    chk("arst_wd3",     rf_wd3, 32'd0);
    chk("arst_a_ready", {31'd0, a_ready}, 32'd0);
    chk("arst_b_ready", {31'd0, b_ready}, 32'd0);
    tick();
    chk("arst_hold_we", {31'd0, rf_we}, 32'd0);
    reset = 1'b0;
    #1;
    chk("post_rst_a_ready", {31'd0, a_ready}, 32'd1);
    chk("post_rst_b_ready", {31'd0, b_ready}, 32'd0);
    tick();
    chk("post_rst_a3", {27'd0, rf_a3}, 32'd9);
    chk("post_rst_we", {31'd0, rf_we}, 32'd1);
    a_valid = 1'b0;
    b_valid = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule
